// File: rtl/mult_pkg.sv
// Shared encodings for the multiplier sequencer and mult_control.
// Sequencer states, count step codes and controller state codes for cross-checking.
package mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_STEP  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } seq_state_t;

  localparam logic [1:0] CNT_LL = 2'b00;
  localparam logic [1:0] CNT_LH = 2'b01;
  localparam logic [1:0] CNT_HL = 2'b10;
  localparam logic [1:0] CNT_HH = 2'b11;

  // mult_control state codes, mirrored here so both sides agree on debug decode
  localparam logic [1:0] MC_IDLE = 2'd0;
  localparam logic [1:0] MC_CALC = 2'd1;
  localparam logic [1:0] MC_DONE = 2'd2;

endpackage

// File: rtl/mult_seq_timer.sv
// Load/enable/expire down-counter bounding the wait for done; expire is combinational.
// Load value N expires on the (N+1)th enabled cycle.
module mult_seq_timer #(
  parameter int TO_W = 4
) (
  input  logic            clk,
  input  logic            reset_a,
  input  logic            load,
  input  logic [TO_W-1:0] load_val,
  input  logic            en,
  output logic            expire
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset_a) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/mult_sequencer.sv
// Initiator for the mult_control start/count/done protocol: request in, product out.
// Optional done timeout under MULT_SEQ_TIMEOUT_EN; default build waits for done indefinitely.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int OP_W        = 8
`ifdef MULT_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 8,
  parameter int TO_W        = 4
`endif
) (
  input  logic              clk,
  input  logic              reset_a,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_a,
  input  logic [OP_W-1:0]   req_b,
  output logic [OP_W-1:0]   op_a,
  output logic [OP_W-1:0]   op_b,
  output logic              start,
  output logic [1:0]        count,
  input  logic              done,
  input  logic [2*OP_W-1:0] product_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*OP_W-1:0] rsp_product,
  output logic              rsp_err,
  output logic              spurious,
  output logic [2:0]        seq_state
);

  seq_state_t state, state_nxt;
  logic [1:0] count_nxt;
  logic       accept;
  logic       capture;
  logic       tmo_fire;
  logic       timeout;

  always_ff @(posedge clk) begin
    if (reset_a) begin
      state       <= S_IDLE;
      count       <= CNT_LL;
      op_a        <= '0;
      op_b        <= '0;
      rsp_product <= '0;
      spurious    <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (accept) begin
        op_a <= req_a;
        op_b <= req_b;
      end
      if (capture) begin
        rsp_product <= product_in;
      end else if (tmo_fire) begin
        rsp_product <= '0;
      end
      // done outside S_WAIT never completes anything but is remembered
      if (done && (state != S_WAIT)) begin
        spurious <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    accept    = 1'b0;
    capture   = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      S_IDLE: begin
        count_nxt = CNT_LL;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        count_nxt = CNT_LL;
        state_nxt = S_STEP;
      end
      S_STEP: begin
        if (count == CNT_HH) begin
          state_nxt = S_WAIT;
        end else begin
          count_nxt = count + 2'd1;
        end
      end
      S_WAIT: begin
        count_nxt = CNT_HH;
        if (done) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end else if (timeout) begin
          tmo_fire  = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          count_nxt = CNT_LL;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        count_nxt = CNT_LL;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign start     = (state == S_START);
  assign rsp_valid = (state == S_RESP);
  assign seq_state = state;

`ifdef MULT_SEQ_TIMEOUT_EN
  logic rsp_err_q;

  // Loaded on the last count step so the first S_WAIT cycle sees the full budget
  mult_seq_timer #(.TO_W(TO_W)) u_timer (
    .clk      (clk),
    .reset_a  (reset_a),
    .load     ((state == S_STEP) && (count == CNT_HH)),
    .load_val (TO_W'(TIMEOUT_CYC - 1)),
    .en       (state == S_WAIT),
    .expire   (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset_a) begin
      rsp_err_q <= 1'b0;
    end else if (capture) begin
      rsp_err_q <= 1'b0;
    end else if (tmo_fire) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer; the bench plays mult_control's done and the datapath product.
module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        reset_a;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_a, req_b;
  logic [7:0]  op_a, op_b;
  logic        start;
  logic [1:0]  count;
  logic        done;
  logic [15:0] product_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_product;
  logic        rsp_err;
  logic        spurious;
  logic [2:0]  seq_state;

  int total = 0;
  int bad   = 0;

  mult_sequencer dut (
    .clk         (clk),
    .reset_a     (reset_a),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .op_a        (op_a),
    .op_b        (op_b),
    .start       (start),
    .count       (count),
    .done        (done),
    .product_in  (product_in),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .spurious    (spurious),
    .seq_state   (seq_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept edge is T0; samples taken 1ns into each following cycle.
  task automatic do_txn(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int hold);
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    req_a     = 8'h5A;
    req_b     = 8'hA5;
    chk("c1_start", 32'(start), 32'd1);
    chk("c1_state", 32'(seq_state), 32'd1);
    chk("op_a", 32'(op_a), 32'(a));
    chk("op_b", 32'(op_b), 32'(b));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("step_count", 32'(count), 32'(i));
      chk("step_start", 32'(start), 32'd0);
      chk("step_req_ready", 32'(req_ready), 32'd0);
    end
    tick();
    chk("c6_state", 32'(seq_state), 32'd3);
    chk("c6_count", 32'(count), 32'd3);
    tick();
    chk("c7_rsp_valid", 32'(rsp_valid), 32'd0);
    done       = 1'b1;
    product_in = 16'(a) * 16'(b);
    tick();
    done       = 1'b0;
    product_in = 16'hDEAD;
    chk("c8_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("c8_product", 32'(rsp_product), 32'(exp));
    chk("c8_err", 32'(rsp_err), 32'd0);
    chk("c8_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_product", 32'(rsp_product), 32'(exp));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_state", 32'(seq_state), 32'd0);
  endtask

  initial begin
    reset_a    = 1'b1;
    req_valid  = 1'b0;
    req_a      = 8'h00;
    req_b      = 8'h00;
    done       = 1'b0;
    product_in = 16'h0000;
    rsp_ready  = 1'b1;
    tick();
    tick();
    chk("rst_state", 32'(seq_state), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_op_b", 32'(op_b), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_product", 32'(rsp_product), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_spurious", 32'(spurious), 32'd0);
    reset_a = 1'b0;
    tick();

    do_txn(8'h0F, 8'h11, 16'h00FF, 0);
    do_txn(8'hFF, 8'hFF, 16'hFE01, 0);
    do_txn(8'h00, 8'hAB, 16'h0000, 0);
    do_txn(8'h80, 8'h02, 16'h0100, 0);
    do_txn(8'h0C, 8'h0D, 16'h009C, 5);
    chk("no_spurious_yet", 32'(spurious), 32'd0);

    // Reset asserted during cycle 4 of a transaction
    req_a     = 8'h12;
    req_b     = 8'h34;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_count", 32'(count), 32'd2);
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    chk("midrst_state", 32'(seq_state), 32'd0);
    chk("midrst_start", 32'(start), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrst_quiet", 32'(rsp_valid), 32'd0);
    end
    do_txn(8'h07, 8'h09, 16'h003F, 0);

    // done coinciding with reset must not set spurious
    reset_a = 1'b1;
    done    = 1'b1;
    tick();
    reset_a = 1'b0;
    done    = 1'b0;
    chk("rst_beats_done", 32'(spurious), 32'd0);

    // Spurious done in S_IDLE
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("spurious_set", 32'(spurious), 32'd1);
    chk("spurious_no_rsp", 32'(rsp_valid), 32'd0);
    chk("spurious_idle", 32'(seq_state), 32'd0);
    tick();
    tick();
    chk("spurious_sticky", 32'(spurious), 32'd1);
    chk("spurious_still_no_rsp", 32'(rsp_valid), 32'd0);

`ifdef MULT_SEQ_TIMEOUT_EN
    // No done: eight S_WAIT cycles (6..13), error response in cycle 14
    req_a     = 8'h22;
    req_b     = 8'h33;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < 13; i++) tick();
    chk("to_c13_state", 32'(seq_state), 32'd3);
    chk("to_c13_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_product", 32'(rsp_product), 32'd0);
    tick();
    chk("to_back_idle", 32'(seq_state), 32'd0);
    do_txn(8'h03, 8'h05, 16'h000F, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
